// File: rtl/btn_click_classifier.sv
// Classifies debounced press ticks into single/double (and optionally triple) click events.
// Optional triple-click support is enabled by defining BTN_CLICK_TRIPLE_EN.
module btn_click_classifier #(
    parameter int MS_DIV    = 100_000,
    parameter int WINDOW_MS = 250,
    localparam int MS_W     = $clog2(MS_DIV),
    localparam int WIN_W    = $clog2(WINDOW_MS + 1)
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iBtnTick,
    input  logic iEn,
    output logic oSingle,
    output logic oDouble,
    output logic oTriple,
    output logic oBusy
);

`ifdef BTN_CLICK_TRIPLE_EN
    typedef enum logic [1:0] {IDLE, WAIT1, WAIT2} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT1} state_t;
`endif

    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_DIV - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_MS - 1);

    state_t           rState;
    logic [MS_W-1:0]  rMsCnt;
    logic [WIN_W-1:0] rWinCnt;
    logic             wMsTick;
    logic             wExpire;
    logic             wOpen;
    logic             wHold;

    assign wMsTick = (rMsCnt == MS_LAST);
    assign wExpire = wMsTick && (rWinCnt == WIN_LAST);
    assign wOpen   = (rState != IDLE);
    // Counters only run while a window is open and nothing ends or restarts it.
    assign wHold   = wOpen && iEn && !iBtnTick && !wExpire;
    assign oBusy   = wOpen;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rMsCnt  <= '0;
            rWinCnt <= '0;
        end else if (wHold) begin
            rMsCnt <= wMsTick ? '0 : rMsCnt + 1'b1;
            if (wMsTick)
                rWinCnt <= rWinCnt + 1'b1;
        end else begin
            rMsCnt  <= '0;
            rWinCnt <= '0;
        end
    end

`ifndef BTN_CLICK_TRIPLE_EN
    assign oTriple = 1'b0;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rState  <= IDLE;
            oSingle <= 1'b0;
            oDouble <= 1'b0;
`ifdef BTN_CLICK_TRIPLE_EN
            oTriple <= 1'b0;
`endif
        end else begin
            oSingle <= 1'b0;
            oDouble <= 1'b0;
`ifdef BTN_CLICK_TRIPLE_EN
            oTriple <= 1'b0;
`endif
            case (rState)
                IDLE: begin
                    if (iBtnTick && iEn)
                        rState <= WAIT1;
                end
                WAIT1: begin
                    // Disable aborts first; a tick beats a coincident expiry.
                    if (!iEn) begin
                        rState <= IDLE;
                    end else if (iBtnTick) begin
`ifdef BTN_CLICK_TRIPLE_EN
                        rState <= WAIT2;
`else
                        rState  <= IDLE;
                        oDouble <= 1'b1;
`endif
                    end else if (wExpire) begin
                        rState  <= IDLE;
                        oSingle <= 1'b1;
                    end
                end
`ifdef BTN_CLICK_TRIPLE_EN
                WAIT2: begin
                    if (!iEn) begin
                        rState <= IDLE;
                    end else if (iBtnTick) begin
                        rState  <= IDLE;
                        oTriple <= 1'b1;
                    end else if (wExpire) begin
                        rState  <= IDLE;
                        oDouble <= 1'b1;
                    end
                end
`endif
                default: rState <= IDLE;
            endcase
        end
    end

endmodule
